// File: rtl/gf8_reduce_pipe.sv
// gf8_reduce_pipe
//   Two-stage pipelined reduction of a 15-bit carry-less product modulo an
//   irreducible degree-8 polynomial x^8 + POLY. It sits directly after the
//   carry-less high-half multiplier.
//
//   Product P[14:0] = {in_hi, in_lo}. Reduction step k clears P[k] by
//   XOR-ing in ({1'b1, POLY} << (k-8)) when that bit is set.
//     stage 1: steps k = 14..11 -> register P[10:0]
//     stage 2: steps k = 10..8  -> register P[7:0] (out_data)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream word valid
//   in_ready   block accepts a word this cycle
//   in_hi      product bits 14..7 (in_hi[0] = bit 7)
//   in_lo      product bits 6..0
//   out_valid  reduced result valid
//   out_ready  downstream accepts the result
//   out_data   reduced 8-bit result
//   out_count  results accepted downstream, wrapping
module gf8_reduce_pipe #(
  parameter logic [7:0] POLY  = 8'h1B,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_hi,
  input  logic [6:0]       in_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [8:0] FULL_POLY = {1'b1, POLY};

  logic             s1_valid_q;
  logic [10:0]      s1_data_q;
  logic [10:0]      s1_data_d;
  logic             s2_valid_q;
  logic [7:0]       s2_data_q;
  logic [7:0]       s2_data_d;
  logic [CNT_W-1:0] count_q;

  logic s1_adv;
  logic s2_adv;
  logic s1_load;

  // A stage can move when it is empty or the stage after it is moving, so a
  // full pipe with out_ready high accepts and emits in the same edge.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;

  // Stage 1 reduction: bits 14 down to 11, highest first so that each step
  // sees the bits introduced by the previous one.
  always_comb begin
    logic [14:0] p;
    p = {in_hi, in_lo};
    for (int k = 14; k >= 11; k--) begin
      if (p[k]) begin
        p = p ^ (15'(FULL_POLY) << (k - 8));
      end
    end
    s1_data_d = p[10:0];
  end

  // Stage 2 reduction: bits 10 down to 8 of the stage-1 word.
  always_comb begin
    logic [10:0] p;
    p = s1_data_q;
    for (int k = 10; k >= 8; k--) begin
      if (p[k]) begin
        p = p ^ (11'(FULL_POLY) << (k - 8));
      end
    end
    s2_data_d = p[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      // Data only changes on an actual load; a bubble keeps the old word.
      if (s1_load) begin
        s1_data_q <= s1_data_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      s2_data_q  <= s2_data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (s2_valid_q && out_ready) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_gf8_reduce_pipe.sv
// tb_gf8_reduce_pipe
//   Directed checks of gf8_reduce_pipe with the default AES polynomial 0x11B.
//   Expected results are hand-reduced constants; useful reference powers:
//   x^8=1B x^9=36 x^10=6C x^11=D8 x^12=AB x^13=4D x^14=9A.
module tb_gf8_reduce_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_hi;
  logic [6:0]  in_lo;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [15:0] out_count;

  int n_tests;
  int n_fail;

  gf8_reduce_pipe #(
    .POLY  (8'h1B),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_hi     (in_hi),
    .in_lo     (in_lo),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one word to an empty pipe with out_ready high and check that the
  // result appears exactly two edges after it is presented.
  task automatic send_one(input string tag, input logic [7:0] hi, input logic [6:0] lo,
                          input logic [7:0] exp);
    in_valid  = 1'b1;
    in_hi     = hi;
    in_lo     = lo;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    step();
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_hi     = 8'h00;
    in_lo     = 7'h00;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    #10 rst = 1'b0;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // AES vector 0x57*0x83 = 0x2B79 -> 0xC1, counter reaches 1
    send_one("aes", 8'h56, 7'h79, 8'hC1);
    chk("aes_count", 32'(out_count), 32'd1);

    // No reduction, single high bits, all ones
    send_one("noreduce", 8'h00, 7'h05, 8'h05);
    send_one("x14", 8'h80, 7'h00, 8'h9A);
    send_one("x8", 8'h02, 7'h00, 8'h1B);
    send_one("all_ones", 8'hFF, 7'h7F, 8'h1A);
    chk("single_count", 32'(out_count), 32'd5);

    // Back-to-back: x^9, x^10, x^11, x^12 on consecutive cycles
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_hi = 8'h04; in_lo = 7'h00;
    step();
    chk("b2b_ready0", 32'(in_ready), 32'd1);
    in_hi = 8'h08;
    step();
    chk("b2b_v0", 32'(out_valid), 32'd1);
    chk("b2b_d0", 32'(out_data), 32'h36);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    in_hi = 8'h10;
    step();
    chk("b2b_v1", 32'(out_valid), 32'd1);
    chk("b2b_d1", 32'(out_data), 32'h6C);
    chk("b2b_ready2", 32'(in_ready), 32'd1);
    in_hi = 8'h20;
    step();
    chk("b2b_v2", 32'(out_valid), 32'd1);
    chk("b2b_d2", 32'(out_data), 32'hD8);
    chk("b2b_ready3", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    step();
    chk("b2b_v3", 32'(out_valid), 32'd1);
    chk("b2b_d3", 32'(out_data), 32'hAB);
    step();
    chk("b2b_empty", 32'(out_valid), 32'd0);
    chk("b2b_count", 32'(out_count), 32'd9);

    // Backpressure: stream x^13, x^8, x^14, x^7 with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_hi = 8'h40; in_lo = 7'h00;
    step();
    chk("bp_ready_a", 32'(in_ready), 32'd1);
    in_hi = 8'h02;
    step();
    chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_hold_v", 32'(out_valid), 32'd1);
    chk("bp_hold_d", 32'(out_data), 32'h4D);
    in_hi = 8'h80;
    step();
    step();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_v", 32'(out_valid), 32'd1);
    chk("bp_stall_d", 32'(out_data), 32'h4D);
    chk("bp_stall_count", 32'(out_count), 32'd9);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 32'd1);
    step();
    chk("bp_drain_b", 32'(out_data), 32'h1B);
    chk("bp_drain_bv", 32'(out_valid), 32'd1);
    in_hi = 8'h01;
    step();
    chk("bp_drain_c", 32'(out_data), 32'h9A);
    chk("bp_drain_cv", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("bp_drain_d", 32'(out_data), 32'h80);
    chk("bp_drain_dv", 32'(out_valid), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_count", 32'(out_count), 32'd13);

    // Asynchronous reset with both stages holding words
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_hi = 8'h02; in_lo = 7'h00;
    step();
    in_hi = 8'h04;
    step();
    in_valid = 1'b0;
    chk("mid_full_v", 32'(out_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_v", 32'(out_valid), 32'd0);
    chk("mid_rst_d", 32'(out_data), 32'd0);
    chk("mid_rst_count", 32'(out_count), 32'd0);
    #2 rst = 1'b0;
    step();
    chk("mid_after_v", 32'(out_valid), 32'd0);
    chk("mid_after_ready", 32'(in_ready), 32'd1);
    send_one("post_rst", 8'h40, 7'h00, 8'h4D);
    chk("post_rst_count", 32'(out_count), 32'd1);

    // Counter wrap: 65536 results from a clean counter
    rst = 1'b1;
    #2 rst = 1'b0;
    chk("wrap_start", 32'(out_count), 32'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_hi = 8'h00; in_lo = 7'h01;
    for (int i = 0; i < 65536; i++) begin
      step();
    end
    in_valid = 1'b0;
    chk("wrap_pre2", 32'(out_count), 32'hFFFE);
    step();
    chk("wrap_pre1", 32'(out_count), 32'hFFFF);
    chk("wrap_last_v", 32'(out_valid), 32'd1);
    chk("wrap_last_d", 32'(out_data), 32'h01);
    step();
    chk("wrap_zero", 32'(out_count), 32'd0);
    chk("wrap_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gf8_reduce_pipe.md
Name: gf8_reduce_pipe

Overview:
- Pipelined GF(2^8) modular-reduction stage sitting directly downstream of the carry-less high-half multiplier.
- Inputs: the 15-bit carry-less product, split as the high-half block's 8-bit output (product bits 14..7) plus the low 7 bits (bits 6..0).
- Output: the product reduced modulo a parameterised irreducible degree-8 polynomial.
- Two register stages, valid/ready handshake, full throughput, 16-bit completed-result counter.

Parameters:
- POLY, 8'h1B, low 8 bits of the irreducible polynomial (x^8 is implicit); default is the AES polynomial 0x11B.
- CNT_W, 16, width of the result counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream data valid
- in_ready  output  1  block can accept this cycle
- in_hi  input  8  product bits 14..7 (in_hi[0] = bit 7)
- in_lo  input  7  product bits 6..0
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts
- out_data  output  8  reduced result
- out_count  output  CNT_W  number of results accepted downstream, wrapping

Behaviour:
- One clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - s1_valid, s2_valid, out_valid = 0
  - out_data = 0, out_count = 0
  - all pipeline data registers = 0
  - in_ready = 1 in the first cycle after reset deassert.
- Product P[14:0] = {in_hi, in_lo}.
- Reduction step k: if P[k] = 1, then P ^= ({1'b1, POLY} << (k-8)).
  - Stage 1 (combinational before reg s1): steps k = 14, 13, 12, 11, strictly in that order; register P[10:0].
  - Stage 2 (combinational before reg s2): steps k = 10, 9, 8 on the s1 value; register P[7:0] as out_data.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational path from out_ready is allowed).
- Transfers:
  - in_valid & in_ready: s1 loads, s1_valid <= 1.
  - s1_adv & !in_valid: s1_valid <= 0.
  - s2_adv: s2 loads s1 data, s2_valid <= s1_valid.
- out_valid = s2_valid; out_data = s2 data register.
- Latency: 2 cycles. A word accepted at edge N is valid after edge N+2 if unstalled.
- Throughput: 1 result per cycle when out_ready is held high.
- Stall: with out_valid=1 and out_ready=0, out_data and out_valid hold stable. s1 still fills if empty. Once both stages are valid, in_ready drops to 0. No data loss or duplication.
- Simultaneous accept/emit when full with out_ready=1: s2 takes s1, s1 takes the new input in the same edge.
- out_count increments on every out_valid & out_ready edge and wraps 0xFFFF -> 0x0000.
- Reset mid-operation clears all valid bits and in-flight data immediately (asynchronous). Nothing is emitted for in-flight words, and out_count returns to 0.
- Data registers must not change when their stage does not advance.

Test Plan:
- AES vector: in_hi=8'h56, in_lo=7'h79 (P=0x2B79, i.e. 0x57·0x83) with out_ready=1 -> out_data=8'hC1, out_valid exactly 2 cycles later, out_count=1.
- No reduction and top bit only:
  - in_hi=8'h00, in_lo=7'h05 -> out_data=8'h05.
  - in_hi=8'h80, in_lo=0 (x^14) -> out_data=8'h9A.
  - in_hi=8'h02, in_lo=0 (x^8) -> out_data=8'h1B.
- Back-to-back: 4 words on consecutive cycles with out_ready=1 -> 4 results on 4 consecutive cycles, in order; in_ready stays 1 throughout.
- Backpressure: out_ready=0 while streaming -> in_ready falls after 2 accepts and the first result holds stable. Raise out_ready -> results drain in order with no gaps, loss, or duplicates.
- Reset mid-flight: assert rst asynchronously (between edges) with both stages valid -> out_valid=0, out_data=0, out_count=0 immediately. After release, a new vector produces the correct result with 2-cycle latency.
- Counter wrap: force 65536 accepted results -> out_count returns to 0.
